pifo_ingress_dispatch: RTL and testbench
========================================

Name: pifo_ingress_dispatch

Overview:
- Single-stream front end for the multi-tree SRAM PIFO top.
- Accepts one push/pop request per cycle on a valid/ready interface and steers it to home port `tree_id & (LEVEL-1)` on the per-level push/pop ports.
- Guards against overflowing the per-port task FIFOs with credit counters.
- Drops pops to empty trees, using per-tree occupancy counters.

Parameters:
- PTW, 16, payload width (MTW fixed 0 in this stage)
- LEVEL, 4, number of per-level ports / RPUs; power of two
- TREE_NUM, 4, number of logical trees; power of two, >= LEVEL
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width
- FIFO_SIZE, 8, task FIFO depth per port = initial credits
- CRW, $clog2(FIFO_SIZE)+1, credit counter width
- CTW, 10, per-tree occupancy counter width

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready
- i_op  in  1  1=push, 0=pop
- i_tree_id  in  TREE_NUM_BITS  target tree
- i_data  in  PTW  push payload (ignored for pop)
- i_credit  in  LEVEL  per-port credit return pulse (task FIFO popped)
- o_push  out  LEVEL  per-port push strobe
- o_pop  out  LEVEL  per-port pop strobe
- o_tree_id  out  TREE_NUM_BITS x LEVEL  per-port tree id
- o_push_data  out  PTW x LEVEL  per-port payload
- o_drop  out  1  pulse: accepted request discarded
- o_credit_err  out  1  sticky: credit return beyond FIFO_SIZE

Behaviour:
- Reset values:
  - all outputs 0
  - credit[p] = FIFO_SIZE
  - occ[t] = 0
  - o_credit_err = 0
  - Reset asserted mid-operation discards any registered request; the output strobe is cleared immediately (async).
- Home port: hp = i_tree_id & (LEVEL-1).
- o_ready is combinational from i_tree_id and state:
  - o_ready = (credit[hp] != 0) | would_drop
  - would_drop = pop with occ[i_tree_id]==0, or push with occ[i_tree_id]==2^CTW-1
- Accept in cycle N (not dropped):
  - Cycle N+1: exactly one of o_push[hp] or o_pop[hp] is high for one cycle.
  - o_tree_id[hp] = tree id; o_push_data[hp] = data for push, 0 for pop.
  - Other ports' strobes are 0.
  - credit[hp] decrements.
  - occ[t] increments on push, decrements on pop.
- Accept in cycle N (dropped):
  - o_drop = 1 in N+1; no port strobe.
  - Credit and occupancy are unchanged.
- Credit return: i_credit[p] high in cycle M adds 1 to credit[p], visible in M+1.
- Same-cycle issue and return on the same port: net credit change is 0.
- Return while credit[p]==FIFO_SIZE (and no same-cycle issue): credit saturates, o_credit_err sets and stays set until reset.
- No valid: all strobes 0 the next cycle. Data outputs hold their last value; not-strobed data is don't-care for consumers.
- State machine (controller):
  - INIT: one cycle after reset release; o_ready = 0.
  - INIT -> RUN unconditionally.
  - RUN: normal operation; stays in RUN until reset.
- Throughput: 1 request/cycle while credits are available. Latency: 1 cycle.

Optional Feature:
- Macro: PIFO_DISPATCH_STATS_EN
- Defined, extra outputs:
  - o_issue_cnt, 32 x LEVEL: per-port accepted, non-dropped requests
  - o_drop_cnt, 32: dropped requests
  - o_stall_cnt, 32: cycles with i_valid & !o_ready
  - All counters wrap, reset to 0, and update in the cycle after the event.
- Undefined: these ports and counters do not exist; the core behaviour above is identical.

Decomposition:
- Package pifo_dispatch_pkg:
  - typedef op_e {OP_POP=0, OP_PUSH=1}
  - typedef state_e {ST_INIT, ST_RUN}
  - function home_port(tree_id)
  - localparam OCC_MAX
- One sub-module: pifo_credit_ctr, instantiated LEVEL times.
  - Inputs: take, give. Outputs: credit, nonzero, overflow.
  - Saturating up/down counter.

Test Plan (LEVEL=4, TREE_NUM=4, FIFO_SIZE=8):
- Reset, then push tree 2 data 0x1234 -> o_ready low for one INIT cycle; after accept, o_push=4'b0100 and o_push_data[2]=0x1234 one cycle later; credit[2]=7, occ[2]=1.
- Nine back-to-back pushes to tree 1, no i_credit -> first 8 accepted; 9th sees o_ready=0 until an i_credit[1] pulse, then accepted the following cycle.
- Pop tree 3 with occ[3]=0 -> accepted, o_drop=1 one cycle later, o_pop=0, credit[3] stays 8.
- credit[0]=7 with same-cycle accept-to-port-0 and i_credit[0] -> credit[0] stays 7, o_push[0] strobes.
- i_credit[2] with credit[2]=8 -> credit stays 8, o_credit_err=1 and stays set through later traffic until i_arst_n low.
- Assert i_arst_n low during a streaming burst -> all strobes drop immediately; after release, credits=8 and occupancies=0, one INIT cycle, then accepts resume.

Source files
------------

// File: rtl/pifo_dispatch_pkg.sv
// Shared types and helpers for the PIFO ingress dispatcher.
package pifo_dispatch_pkg;

  typedef enum logic {OP_POP = 1'b0, OP_PUSH = 1'b1} op_e;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  // Per-tree occupancy counter width and its saturation point.
  localparam int unsigned CTW     = 10;
  localparam int unsigned OCC_MAX = (1 << CTW) - 1;

  // Trees fold onto ports by their low bits; level must be a power of two.
  function automatic int unsigned home_port(input int unsigned tree_id,
                                            input int unsigned level);
    return tree_id & (level - 1);
  endfunction

endpackage

// File: rtl/pifo_credit_ctr.sv
// Per-port task FIFO credit counter: saturating up/down with sticky overflow.
module pifo_credit_ctr #(
  parameter int unsigned FIFO_SIZE = 8,
  parameter int unsigned CRW       = $clog2(FIFO_SIZE) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           take,
  input  logic           give,
  output logic [CRW-1:0] credit,
  output logic           nonzero,
  output logic           overflow
);

  localparam logic [CRW-1:0] FULL = CRW'(FIFO_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit   <= FULL;
      overflow <= 1'b0;
    end else begin
      case ({take, give})
        2'b10: if (credit != '0) credit <= credit - 1'b1;
        2'b01: begin
          // A return with every slot already free means the consumer miscounted.
          if (credit == FULL) overflow <= 1'b1;
          else                credit   <= credit + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign nonzero = (credit != '0);

endmodule

// File: rtl/pifo_ingress_dispatch.sv
// Single-stream front end steering push/pop requests to per-level PIFO ports.
// Optional statistics counters are built when PIFO_DISPATCH_STATS_EN is defined.
module pifo_ingress_dispatch
  import pifo_dispatch_pkg::*;
#(
  parameter int unsigned PTW           = 16,
  parameter int unsigned LEVEL         = 4,
  parameter int unsigned TREE_NUM      = 4,
  parameter int unsigned TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int unsigned FIFO_SIZE     = 8,
  parameter int unsigned CRW           = $clog2(FIFO_SIZE) + 1
) (
  input  logic                                i_clk,
  input  logic                                i_arst_n,
  // Handshake: a request transfers in any cycle where i_valid & o_ready;
  // o_ready depends only on i_op/i_tree_id and state, never on i_valid.
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic                                i_op,
  input  logic [TREE_NUM_BITS-1:0]            i_tree_id,
  input  logic [PTW-1:0]                      i_data,
  input  logic [LEVEL-1:0]                    i_credit,
  output logic [LEVEL-1:0]                    o_push,
  output logic [LEVEL-1:0]                    o_pop,
  output logic [LEVEL-1:0][TREE_NUM_BITS-1:0] o_tree_id,
  output logic [LEVEL-1:0][PTW-1:0]           o_push_data,
  output logic                                o_drop,
  output logic                                o_credit_err,
  output state_e                              o_dbg_state,
  output logic [LEVEL-1:0][CRW-1:0]           o_dbg_credit
`ifdef PIFO_DISPATCH_STATS_EN
  ,
  output logic [LEVEL-1:0][31:0]              o_issue_cnt,
  output logic [31:0]                         o_drop_cnt,
  output logic [31:0]                         o_stall_cnt
`endif
);

  state_e           state_q, state_d;
  logic             run;
  logic [CTW-1:0]   occ [TREE_NUM];
  logic [CTW-1:0]   cur_occ;
  logic             is_push;
  logic             would_drop;
  logic [LEVEL-1:0] hp_hit;
  logic [LEVEL-1:0] credit_nz;
  logic [LEVEL-1:0] overflow;
  logic [LEVEL-1:0] take;
  logic             accept;
  logic             issue;

  // Controller: state register, next state, outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= ST_INIT;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    run = (state_q == ST_RUN);
  end

  assign o_dbg_state = state_q;

  // Request decode.
  assign is_push    = (op_e'(i_op) == OP_PUSH);
  assign cur_occ    = occ[i_tree_id];
  assign would_drop = is_push ? (cur_occ == CTW'(OCC_MAX)) : (cur_occ == '0);

  for (genvar p = 0; p < LEVEL; p++) begin : g_port
    assign hp_hit[p] = (home_port(32'(i_tree_id), LEVEL) == 32'(p));

    pifo_credit_ctr #(.FIFO_SIZE(FIFO_SIZE), .CRW(CRW)) u_credit (
      .clk      (i_clk),
      .rst_n    (i_arst_n),
      .take     (take[p]),
      .give     (i_credit[p]),
      .credit   (o_dbg_credit[p]),
      .nonzero  (credit_nz[p]),
      .overflow (overflow[p])
    );
  end

  // Requests that will be dropped never consume a credit, so they are always accepted.
  assign o_ready      = run & ((|(credit_nz & hp_hit)) | would_drop);
  assign accept       = i_valid & o_ready;
  assign issue        = accept & ~would_drop;
  assign take         = {LEVEL{issue}} & hp_hit;
  assign o_credit_err = |overflow;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int t = 0; t < TREE_NUM; t++) occ[t] <= '0;
    end else if (issue) begin
      if (is_push) occ[i_tree_id] <= cur_occ + 1'b1;
      else         occ[i_tree_id] <= cur_occ - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_push      <= '0;
      o_pop       <= '0;
      o_drop      <= 1'b0;
      o_tree_id   <= '0;
      o_push_data <= '0;
    end else begin
      o_push <= (issue &  is_push) ? hp_hit : '0;
      o_pop  <= (issue & ~is_push) ? hp_hit : '0;
      o_drop <= accept & would_drop;
      for (int p = 0; p < LEVEL; p++) begin
        if (take[p]) begin
          o_tree_id[p]   <= i_tree_id;
          o_push_data[p] <= is_push ? i_data : '0;
        end
      end
    end
  end

`ifdef PIFO_DISPATCH_STATS_EN
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_issue_cnt <= '0;
      o_drop_cnt  <= '0;
      o_stall_cnt <= '0;
    end else begin
      for (int p = 0; p < LEVEL; p++) begin
        if (take[p]) o_issue_cnt[p] <= o_issue_cnt[p] + 32'd1;
      end
      if (accept & would_drop) o_drop_cnt  <= o_drop_cnt + 32'd1;
      if (i_valid & ~o_ready)  o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pifo_ingress_dispatch.sv
// Directed bench for pifo_ingress_dispatch with a queue-level reference model.
module tb_pifo_ingress_dispatch;
  import pifo_dispatch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             i_valid = 1'b0;
  logic             o_ready;
  logic             i_op = 1'b0;
  logic [1:0]       i_tree_id = '0;
  logic [15:0]      i_data = '0;
  logic [3:0]       i_credit = '0;
  logic [3:0]       o_push, o_pop;
  logic [3:0][1:0]  o_tree_id;
  logic [3:0][15:0] o_push_data;
  logic             o_drop, o_credit_err;
  state_e           o_dbg_state;
  logic [3:0][3:0]  o_dbg_credit;
`ifdef PIFO_DISPATCH_STATS_EN
  logic [3:0][31:0] o_issue_cnt;
  logic [31:0]      o_drop_cnt, o_stall_cnt;
`endif

  pifo_ingress_dispatch dut (
    .i_clk        (clk),
    .i_arst_n     (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op         (i_op),
    .i_tree_id    (i_tree_id),
    .i_data       (i_data),
    .i_credit     (i_credit),
    .o_push       (o_push),
    .o_pop        (o_pop),
    .o_tree_id    (o_tree_id),
    .o_push_data  (o_push_data),
    .o_drop       (o_drop),
    .o_credit_err (o_credit_err),
    .o_dbg_state  (o_dbg_state),
    .o_dbg_credit (o_dbg_credit)
`ifdef PIFO_DISPATCH_STATS_EN
    ,
    .o_issue_cnt  (o_issue_cnt),
    .o_drop_cnt   (o_drop_cnt),
    .o_stall_cnt  (o_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Free slots per port, entries per tree, and what each port should show next.
  int          m_credit [4] = '{8, 8, 8, 8};
  int          m_occ    [4] = '{0, 0, 0, 0};
  bit          m_err  = 1'b0;
  bit          m_init = 1'b1;
  logic [3:0]  e_push = '0, e_pop = '0;
  bit          e_drop = 1'b0;
  logic [1:0]  e_tid  [4] = '{default: '0};
  logic [15:0] e_data [4] = '{default: '0};

  function automatic bit m_would_drop();
    if (i_op) return (m_occ[i_tree_id] == 1023);
    return (m_occ[i_tree_id] == 0);
  endfunction

  function automatic bit m_ready();
    if (m_init) return 1'b0;
    return m_would_drop() || (m_credit[int'(i_tree_id) % 4] > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc, drp;
    int hp, nc;
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) begin
        m_credit[p] <= 8;
        m_occ[p]    <= 0;
        e_tid[p]    <= '0;
        e_data[p]   <= '0;
      end
      m_err  <= 1'b0;
      m_init <= 1'b1;
      e_push <= '0;
      e_pop  <= '0;
      e_drop <= 1'b0;
    end else begin
      acc = i_valid && m_ready();
      drp = acc && m_would_drop();
      hp  = int'(i_tree_id) % 4;
      e_drop <= drp;
      e_push <= (acc && !drp &&  i_op) ? 4'(1 << hp) : 4'b0;
      e_pop  <= (acc && !drp && !i_op) ? 4'(1 << hp) : 4'b0;
      if (acc && !drp) begin
        e_tid[hp]  <= i_tree_id;
        e_data[hp] <= i_op ? i_data : 16'h0;
        m_occ[i_tree_id] <= m_occ[i_tree_id] + (i_op ? 1 : -1);
      end
      for (int p = 0; p < 4; p++) begin
        nc = m_credit[p] - ((acc && !drp && p == hp) ? 1 : 0) + (i_credit[p] ? 1 : 0);
        if (nc > 8) begin
          nc = 8;
          m_err <= 1'b1;
        end
        m_credit[p] <= nc;
      end
      m_init <= 1'b0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("ready", 32'(o_ready), 32'(m_ready()));
      chk("push", 32'(o_push), 32'(e_push));
      chk("pop", 32'(o_pop), 32'(e_pop));
      chk("drop", 32'(o_drop), 32'(e_drop));
      chk("credit_err", 32'(o_credit_err), 32'(m_err));
      chk("state_run", 32'(o_dbg_state == ST_RUN), 32'(!m_init));
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("credit[%0d]", p), 32'(o_dbg_credit[p]), 32'(m_credit[p]));
        chk($sformatf("tree_id[%0d]", p), 32'(o_tree_id[p]), 32'(e_tid[p]));
        chk($sformatf("push_data[%0d]", p), 32'(o_push_data[p]), 32'(e_data[p]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit op, input int tid, input logic [15:0] d,
                      input logic [3:0] cr = 4'b0);
    bit rdy;
    i_valid   = 1'b1;
    i_op      = op;
    i_tree_id = 2'(tid);
    i_data    = d;
    i_credit  = cr;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      #1;
      i_credit = '0;
      if (rdy) begin
        i_valid = 1'b0;
        return;
      end
    end
    i_valid = 1'b0;
    chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic pulse_credit(input logic [3:0] cr);
    i_credit = cr;
    @(posedge clk);
    #1;
    i_credit = '0;
  endtask

  initial begin : watchdog
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    started = 1'b1;
    #1;
    chk("reset_push", 32'(o_push), 32'h0);
    chk("reset_credit2", 32'(o_dbg_credit[2]), 32'd8);
    rst_n = 1'b1;

    // First request meets the single INIT cycle, then issues to port 2.
    i_valid = 1'b1; i_op = 1'b1; i_tree_id = 2'd2; i_data = 16'h1234;
    @(negedge clk);
    chk("init_not_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("first_push", 32'(o_push), 32'h4);
    chk("first_data", 32'(o_push_data[2]), 32'h1234);
    chk("model_credit2", 32'(m_credit[2]), 32'd7);
    chk("model_occ2", 32'(m_occ[2]), 32'd1);

    // Exhaust port 1 credits; the ninth push waits for a return.
    for (int k = 0; k < 8; k++) send(1'b1, 1, 16'(16'h0100 + k));
    chk("port1_empty", 32'(o_dbg_credit[1]), 32'd0);
    i_valid = 1'b1; i_op = 1'b1; i_tree_id = 2'd1; i_data = 16'h0109;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", 32'(o_ready), 32'd0);
    end
    @(posedge clk); #1;
    i_credit = 4'b0010;
    @(negedge clk);
    chk("return_not_yet", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    i_credit = '0;
    @(negedge clk);
    chk("return_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("ninth_push", 32'(o_push), 32'h2);
    chk("ninth_data", 32'(o_push_data[1]), 32'h0109);

    // Pop from an empty tree is accepted and dropped.
    send(1'b0, 3, 16'hffff);
    chk("empty_drop", 32'(o_drop), 32'd1);
    chk("empty_no_pop", 32'(o_pop), 32'h0);
    chk("empty_credit3", 32'(o_dbg_credit[3]), 32'd8);

    // Same-cycle issue and return on port 0 leaves credit unchanged.
    send(1'b1, 0, 16'haaaa);
    chk("port0_after_one", 32'(o_dbg_credit[0]), 32'd7);
    send(1'b1, 0, 16'h5555, 4'b0001);
    chk("net_zero_push", 32'(o_push), 32'h1);
    chk("net_zero_credit", 32'(o_dbg_credit[0]), 32'd7);
    chk("model_credit0", 32'(m_credit[0]), 32'd7);

    // Over-return on port 2 sets the sticky error.
    pulse_credit(4'b0100);
    chk("refill_no_err", 32'(o_credit_err), 32'd0);
    pulse_credit(4'b0100);
    chk("over_return_err", 32'(o_credit_err), 32'd1);
    chk("over_return_sat", 32'(o_dbg_credit[2]), 32'd8);
    send(1'b0, 2, 16'h0);
    chk("pop_tree2", 32'(o_pop), 32'h4);
    chk("pop_data_zero", 32'(o_push_data[2]), 32'h0);
    send(1'b1, 3, 16'h7777);
    send(1'b0, 3, 16'h0);
    chk("err_sticky", 32'(o_credit_err), 32'd1);

    // Reset in the middle of a streaming burst.
    i_valid = 1'b1; i_op = 1'b1; i_tree_id = 2'd2; i_data = 16'hc0de;
    @(posedge clk); #1;
    i_tree_id = 2'd3; i_data = 16'hd00d;
    @(posedge clk); #1;
    chk("burst_push", 32'(o_push), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear_push", 32'(o_push), 32'h0);
    chk("async_clear_data", 32'(o_push_data[3]), 32'h0);
    chk("async_clear_err", 32'(o_credit_err), 32'd0);
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_valid = 1'b1; i_op = 1'b0; i_tree_id = 2'd1; i_data = 16'h0;
    @(negedge clk);
    chk("post_reset_init", 32'(o_ready), 32'd0);
    chk("post_reset_credit1", 32'(o_dbg_credit[1]), 32'd8);
    i_valid = 1'b0;
    send(1'b0, 1, 16'h0);
    chk("post_reset_drop", 32'(o_drop), 32'd1);
    send(1'b1, 1, 16'hbeef);
    chk("post_reset_push", 32'(o_push), 32'h2);
    chk("post_reset_data", 32'(o_push_data[1]), 32'hbeef);
    send(1'b0, 1, 16'h0);
    chk("post_reset_pop", 32'(o_pop), 32'h2);

    @(posedge clk); #1;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
